serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
//  Bit-serial N-bit subtractor (diff = a - b) built around a one-bit subtract cell plus a borrow flip-flop.
//  Processes one bit per clock, LSB first, and chains the cell's borrow output into the next bit position.
//  Sits downstream of the combinational half/full subtract cells and consumes their diff/borrow each cycle.
//  Used where area matters more than latency.
// PARAMETERS
//  WIDTH  8  operand/result width in bits; legal range 1..32
// PORTS
//  clk     in   1      single clock, rising edge
//  rst     in   1      synchronous, active-high reset
//  start   in   1      request; sampled only when busy=0
//  a       in   WIDTH  minuend, captured on the accepted start edge
//  b       in   WIDTH  subtrahend, captured on the accepted start edge
//  busy    out  1      high while bits are being processed
//  done    out  1      one-cycle pulse when diff/borrow become valid
//  diff    out  WIDTH  result, a - b modulo 2^WIDTH
//  borrow  out  1      final borrow out; 1 iff a < b (unsigned)
//  ovf     out  1      signed overflow flag; present only with SERSUB_OVF_EN
// BEHAVIOUR
//  - Reset: clk and a single synchronous, active-high rst. On rst=1 at an edge: state=IDLE, busy=0, done=0, diff=0, borrow=0, ovf=0, count=0, borrow_ff=0.
//  - FSM states and transitions:
//    - IDLE -> SHIFT when start=1.
//    - SHIFT -> DONE after exactly WIDTH bit-edges.
//    - DONE -> IDLE, or DONE -> SHIFT if start=1 in DONE.
//  - Accept (IDLE/DONE with start=1): latch a into shreg_a and b into shreg_b; clear borrow_ff, count and the result shift register.
//  - Each SHIFT edge:
//    - d_i   = a_i ^ b_i ^ borrow_ff
//    - bo    = (~a_i & b_i) | (~(a_i ^ b_i) & borrow_ff)
//    - shift d_i into the result MSB and shift shreg_a/shreg_b right
//    - borrow_ff <= bo; count++
//  - Latency: start accepted at edge 0 -> done=1 in the cycle after edge WIDTH+1.
//    - busy=1 from edge 0 through edge WIDTH.
//  - diff and borrow update only on entry to DONE and hold until the next DONE.
//    - They do not toggle during SHIFT; the internal shift register is separate.
//  - start while busy=1: ignored, no queueing.
//  - start in the DONE cycle: accepted; done and a new busy overlap, giving back-to-back operation.
//  - rst mid-SHIFT: operation aborted, outputs cleared, no done pulse.
//  - WIDTH=1: one SHIFT cycle, done two cycles after start.
//  - count is $clog2(WIDTH+1) bits wide and never wraps.
// CONFIGURATION
//  - SERSUB_OVF_EN defined: port ovf exists.
//    - ovf = (a[W-1]^b[W-1]) & (diff[W-1]^a[W-1]), computed from the latched operands.
//    - Valid with done and held with diff.
//  - SERSUB_OVF_EN undefined: no ovf port and no MSB capture logic.
// STRUCTURE
//  - Package sersub_pkg: state encoding (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) and a MAX_WIDTH=32 constant.
//  - Sub-module fs_cell (a, b, bin -> d, bout): a full subtractor made of two half-subtract stages plus an OR.
//    - Instantiated once; the top holds only the FSM, counter, shift registers and borrow_ff.
// TESTING
//  1. WIDTH=8, a=10, b=3, start 1 cycle -> done after 9 edges; diff=8'h07, borrow=0.
//  2. a=3, b=10 -> diff=8'hF9, borrow=1; a=0, b=0 -> diff=0, borrow=0.
//  3. start held high for 20 cycles -> exactly two operations back-to-back.
//     - start pulses during busy are ignored; done pulses exactly 2 times.
//  4. rst asserted on the 4th SHIFT cycle -> all outputs 0 next cycle, no done.
//     - A fresh a=255, b=1 then yields diff=8'hFE.
//  5. SERSUB_OVF_EN, a=8'h80, b=8'h01 -> diff=8'h7F, ovf=1.
//     - a=8'h05, b=8'h03 -> ovf=0.
//  6. WIDTH=1: a=0, b=1 -> diff=1, borrow=1, done 2 cycles after start.

Source files
------------

// File: rtl/sersub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and width limit.
// Optional signed-overflow output is enabled with SERSUB_OVF_EN.
package sersub_pkg;

  localparam int MAX_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sersub_state_e;

endpackage

// File: rtl/serial_subtractor_fs_cell.sv
// One-bit full subtractor: two cascaded half-subtract stages, borrows ORed together.
module fs_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic bin_i,
  output logic d_o,
  output logic bout_o
);

  logic hs1_d;
  logic hs1_b;
  logic hs2_b;

  assign hs1_d  = a_i ^ b_i;
  assign hs1_b  = ~a_i & b_i;
  assign d_o    = hs1_d ^ bin_i;
  assign hs2_b  = ~hs1_d & bin_i;
  assign bout_o = hs1_b | hs2_b;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one bit per clock through a single fs_cell and a borrow flop.
// Define SERSUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor
  import sersub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SERSUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_width_check
    $error("serial_subtractor: WIDTH out of range");
  end

  sersub_state_e    state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             bff_q, bff_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
`ifdef SERSUB_OVF_EN
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             ovf_q, ovf_d;
`endif

  logic cell_d;
  logic cell_bout;

  fs_cell u_cell (
    .a_i    (sa_q[0]),
    .b_i    (sb_q[0]),
    .bin_i  (bff_q),
    .d_o    (cell_d),
    .bout_o (cell_bout)
  );

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    res_d    = res_q;
    bff_d    = bff_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
`ifdef SERSUB_OVF_EN
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = SHIFT;
          sa_d    = a;
          sb_d    = b;
          res_d   = '0;
          bff_d   = 1'b0;
          count_d = '0;
`ifdef SERSUB_OVF_EN
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
`endif
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        // Once every bit is in, publish the result on the following edge.
        if (count_q == CW'(WIDTH)) begin
          state_d  = DONE;
          diff_d   = res_q;
          borrow_d = bff_q;
`ifdef SERSUB_OVF_EN
          ovf_d    = (a_msb_q ^ b_msb_q) & (res_q[WIDTH-1] ^ a_msb_q);
`endif
        end else begin
          res_d            = res_q >> 1;
          res_d[WIDTH-1]   = cell_d;
          sa_d             = sa_q >> 1;
          sb_d             = sb_q >> 1;
          bff_d            = cell_bout;
          count_d          = count_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      sa_q     <= '0;
      sb_q     <= '0;
      res_q    <= '0;
      bff_q    <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
`ifdef SERSUB_OVF_EN
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      res_q    <= res_d;
      bff_q    <= bff_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
`ifdef SERSUB_OVF_EN
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy   = (state_q == SHIFT);
  assign done   = (state_q == DONE);
  assign diff   = diff_q;
  assign borrow = borrow_q;
`ifdef SERSUB_OVF_EN
  assign ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: transaction-level model for WIDTH=8 plus a WIDTH=1 instance.
// Honours SERSUB_OVF_EN for the ovf output.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;
  logic         ovf;

  logic         start1;
  logic [0:0]   a1;
  logic [0:0]   b1;
  logic         busy1;
  logic         done1;
  logic [0:0]   diff1;
  logic         borrow1;
  logic         ovf1;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow)
`ifdef SERSUB_OVF_EN
    ,
    .ovf    (ovf)
`endif
  );

  serial_subtractor #(.WIDTH(1)) dut1 (
    .clk    (clk),
    .rst    (rst),
    .start  (start1),
    .a      (a1),
    .b      (b1),
    .busy   (busy1),
    .done   (done1),
    .diff   (diff1),
    .borrow (borrow1)
`ifdef SERSUB_OVF_EN
    ,
    .ovf    (ovf1)
`endif
  );

`ifndef SERSUB_OVF_EN
  assign ovf  = 1'b0;
  assign ovf1 = 1'b0;
`endif

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  // ---------------- model ----------------
  // Each accepted operation completes WIDTH+1 edges later with {ovf, borrow, a-b}.
  logic [W+1:0] exp_q[$];
  int           rem = 0;
  bit           model_valid = 0;
  logic         m_done = 0;
  logic [W-1:0] m_diff = '0;
  logic         m_borrow = 0;
  logic         m_ovf = 0;

  always @(posedge clk) begin
    bit           acc;
    int           sres;
    logic         sovf;
    logic [W-1:0] dv;
    if (rst) begin
      rem = 0;
      m_done = 0;
      m_diff = '0;
      m_borrow = 0;
      m_ovf = 0;
      exp_q.delete();
      model_valid = 1;
    end else begin
      acc = start && (rem == 0);
      m_done = 0;
      if (rem > 0) begin
        rem--;
        if (rem == 0) begin
          {m_ovf, m_borrow, m_diff} = exp_q.pop_front();
          m_done = 1;
        end
      end
      if (acc) begin
        rem = W + 1;
        dv = a - b;
        sres = int'($signed(a)) - int'($signed(b));
        sovf = (sres < -128) || (sres > 127);
        exp_q.push_back({sovf, (a < b), dv});
      end
    end
  end

  // ---------------- checker ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (model_valid) begin
      chk("cyc busy", 32'(busy), 32'(rem > 0));
      chk("cyc done", 32'(done), 32'(m_done));
      chk("cyc diff", 32'(diff), 32'(m_diff));
      chk("cyc borrow", 32'(borrow), 32'(m_borrow));
`ifdef SERSUB_OVF_EN
      chk("cyc ovf", 32'(ovf), 32'(m_ovf));
`endif
      if (done) done_cnt++;
    end
  end

  // ---------------- drivers ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_done(input bit w1, output bit seen, output int lat);
    seen = 0;
    lat = -1;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if ((w1 ? done1 : done) === 1'b1) begin
        seen = 1;
        lat = i;
      end
    end
  endtask

  task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic [W-1:0] ed, input logic eb, input string nm);
    bit seen;
    int lat;
    start = 1'b1;
    a = av;
    b = bv;
    cyc(1);
    start = 1'b0;
    wait_done(1'b0, seen, lat);
    chk({nm, " done seen"}, 32'(seen), 32'(1));
    chk({nm, " latency"}, 32'(lat), 32'(W + 1));
    chk({nm, " diff"}, 32'(diff), 32'(ed));
    chk({nm, " borrow"}, 32'(borrow), 32'(eb));
    cyc(1);
  endtask

  task automatic do_op1(input logic av, input logic bv, input logic ed, input logic eb,
                        input string nm);
    bit seen;
    int lat;
    start1 = 1'b1;
    a1 = av;
    b1 = bv;
    cyc(1);
    start1 = 1'b0;
    wait_done(1'b1, seen, lat);
    chk({nm, " done seen"}, 32'(seen), 32'(1));
    chk({nm, " latency"}, 32'(lat), 32'(2));
    chk({nm, " diff"}, 32'(diff1), 32'(ed));
    chk({nm, " borrow"}, 32'(borrow1), 32'(eb));
    cyc(1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit seen;
    int lat;
    int c0;
    logic [7:0] va[4] = '{8'd77, 8'd200, 8'd1, 8'd128};
    logic [7:0] vb[4] = '{8'd76, 8'd201, 8'd2, 8'd127};
    logic [7:0] vd[4] = '{8'h01, 8'hFF, 8'hFF, 8'h01};
    logic       vbr[4] = '{1'b0, 1'b1, 1'b1, 1'b0};

    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    start1 = 1'b0;
    a1 = '0;
    b1 = '0;
    cyc(3);
    rst = 1'b0;
    @(negedge clk);
    chk("reset busy", 32'(busy), 32'(0));
    chk("reset done", 32'(done), 32'(0));
    chk("reset diff", 32'(diff), 32'(0));
    chk("reset borrow", 32'(borrow), 32'(0));
    cyc(1);

    do_op(8'd10, 8'd3, 8'h07, 1'b0, "10-3");
    do_op(8'd3, 8'd10, 8'hF9, 1'b1, "3-10");
    do_op(8'd0, 8'd0, 8'h00, 1'b0, "0-0");
    do_op(8'd255, 8'd255, 8'h00, 1'b0, "255-255");
    do_op(8'd0, 8'd255, 8'h01, 1'b1, "0-255");
    for (int i = 0; i < 4; i++) do_op(va[i], vb[i], vd[i], vbr[i], "table");

    do_op(8'h80, 8'h01, 8'h7F, 1'b0, "80-01");
`ifdef SERSUB_OVF_EN
    chk("ovf 80-01", 32'(ovf), 32'(1));
`endif
    do_op(8'h05, 8'h03, 8'h02, 1'b0, "05-03");
`ifdef SERSUB_OVF_EN
    chk("ovf 05-03", 32'(ovf), 32'(0));
`endif

    // start pulse while busy must be dropped
    start = 1'b1;
    a = 8'd100;
    b = 8'd1;
    cyc(1);
    start = 1'b0;
    cyc(3);
    start = 1'b1;
    a = 8'd1;
    b = 8'd100;
    cyc(1);
    start = 1'b0;
    wait_done(1'b0, seen, lat);
    chk("ignore done seen", 32'(seen), 32'(1));
    chk("ignore diff", 32'(diff), 32'(8'h63));
    chk("ignore borrow", 32'(borrow), 32'(0));
    cyc(3);

    // start held 20 cycles: two back-to-back operations
    c0 = done_cnt;
    start = 1'b1;
    a = 8'd200;
    b = 8'd55;
    cyc(20);
    start = 1'b0;
    cyc(15);
    chk("held done pulses", 32'(done_cnt - c0), 32'(2));
    chk("held diff", 32'(diff), 32'(8'h91));

    // reset during the 4th SHIFT cycle
    start = 1'b1;
    a = 8'h12;
    b = 8'h34;
    cyc(1);
    start = 1'b0;
    cyc(3);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    c0 = done_cnt;
    @(negedge clk);
    chk("abort busy", 32'(busy), 32'(0));
    chk("abort done", 32'(done), 32'(0));
    chk("abort diff", 32'(diff), 32'(0));
    chk("abort borrow", 32'(borrow), 32'(0));
    cyc(12);
    chk("abort no done", 32'(done_cnt - c0), 32'(0));
    do_op(8'd255, 8'd1, 8'hFE, 1'b0, "255-1");

    // WIDTH=1 instance
    do_op1(1'b0, 1'b1, 1'b1, 1'b1, "w1 0-1");
    do_op1(1'b1, 1'b0, 1'b1, 1'b0, "w1 1-0");
    do_op1(1'b1, 1'b1, 1'b0, 1'b0, "w1 1-1");

    cyc(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
